// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the fetch-stage program counter.
//   state_e : fetch sequencer states (BOOT, RUN, HALT)
//   src_e   : source selected for the next PC value
//   DEF_*   : default reset / exception vectors
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_JMP = 2'd1,
        SRC_BR  = 2'd2,
        SRC_EXC = 2'd3
    } src_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: control/status bundle between the PC unit and the pipeline.
//   Inputs to the PC unit : stall, if_ready, br_valid/br_target, jmp_valid/jmp_target,
//                           exc_valid, halt_req
//   Outputs of the PC unit: pc, pc_plus, if_valid, redirect, misalign, halted, fetch_cnt
//   modport master: the PC unit (drives the fetch request)
//   modport slave : the pipeline side
interface pc_fetch_ctrl_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             if_ready;
    logic             br_valid;
    logic [W-1:0]     br_target;
    logic             jmp_valid;
    logic [W-1:0]     jmp_target;
    logic             exc_valid;
    logic             halt_req;
    logic [W-1:0]     pc;
    logic [W-1:0]     pc_plus;
    logic             if_valid;
    logic             redirect;
    logic             misalign;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        input  stall, if_ready, br_valid, br_target, jmp_valid, jmp_target, exc_valid, halt_req,
        output pc, pc_plus, if_valid, redirect, misalign, halted, fetch_cnt
    );

    modport slave (
        output stall, if_ready, br_valid, br_target, jmp_valid, jmp_target, exc_valid, halt_req,
        input  pc, pc_plus, if_valid, redirect, misalign, halted, fetch_cnt
    );
endinterface

// File: rtl/pc_reg.sv
// pc_reg: W-bit register with synchronous active-low reset to RST_VAL and a load enable.
//   clk   : clock, rising edge
//   clrn  : synchronous reset, active low (wins over en_i)
//   en_i  : load d_i this cycle
//   d_i   : next value
//   q_o   : registered value
module pc_reg #(
    parameter int unsigned    W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (!clrn)     q_q <= RST_VAL;
        else if (en_i) q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter unit for the fetch stage.
//   clk  : clock, rising edge
//   clrn : synchronous reset, active low
//   bus  : pc_fetch_ctrl_if.master -- stall/handshake/redirect inputs, pc and status outputs
// Redirect priority is exception > branch > jump > sequential advance. BOOT holds if_valid
// low for BOOT_CYCLES cycles after reset, HALT parks the PC until an exception arrives.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned  W           = 32,
    parameter int unsigned  STEP        = 4,
    parameter logic [W-1:0] RESET_VEC   = W'(DEF_RESET_VEC),
    parameter logic [W-1:0] EXC_VEC     = W'(DEF_EXC_VEC),
    parameter int unsigned  BOOT_CYCLES = 2,
    parameter int unsigned  CNT_W       = 32
) (
    input  logic            clk,
    input  logic            clrn,
    pc_fetch_ctrl_if.master bus
);
    localparam int unsigned  BW       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    // STEP is a power of two; these are the byte-offset bits a target must not carry.
    localparam logic [W-1:0] LOW_MASK = W'(STEP - 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    boot_q, boot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redirect_q, redirect_d;
    logic             misalign_q, misalign_d;
    logic             pc_en;
    logic [W-1:0]     pc_q, pc_d, pc_plus_w, tgt;
    src_e             src;

    assign pc_plus_w = pc_q + W'(STEP);

    always_comb begin
        state_d    = state_q;
        boot_d     = boot_q;
        cnt_d      = cnt_q;
        src        = SRC_SEQ;
        pc_en      = 1'b0;
        redirect_d = 1'b0;
        unique case (state_q)
            BOOT: begin
                if (boot_q == BW'(BOOT_CYCLES - 1)) state_d = RUN;
                else                                boot_d  = boot_q + BW'(1);
            end
            RUN: begin
                if (bus.exc_valid)      src = SRC_EXC;
                else if (bus.br_valid)  src = SRC_BR;
                else if (bus.jmp_valid) src = SRC_JMP;
                // Halt takes effect next cycle; this cycle's PC update still happens.
                if (bus.halt_req && !bus.exc_valid) state_d = HALT;
                // Redirects ignore stall/if_ready: they squash whatever is in flight.
                if (src != SRC_SEQ) begin
                    pc_en      = 1'b1;
                    redirect_d = 1'b1;
                end else if (bus.if_ready && !bus.stall) begin
                    pc_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                if (bus.exc_valid) begin
                    src        = SRC_EXC;
                    pc_en      = 1'b1;
                    redirect_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        tgt = pc_plus_w;
        case (src)
            SRC_JMP: tgt = bus.jmp_target;
            SRC_BR:  tgt = bus.br_target;
            SRC_EXC: tgt = EXC_VEC;
            default: tgt = pc_plus_w;
        endcase
    end

    assign pc_d       = tgt & ~LOW_MASK;
    assign misalign_d = ((src == SRC_JMP) || (src == SRC_BR)) && (|(tgt & LOW_MASK));

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q    <= BOOT;
            boot_q     <= '0;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_q     <= boot_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    pc_reg #(.W(W), .RST_VAL(RESET_VEC)) u_pc_reg (
        .clk  (clk),
        .clrn (clrn),
        .en_i (pc_en),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    assign bus.pc        = pc_q;
    assign bus.pc_plus   = pc_plus_w;
    assign bus.if_valid  = (state_q == RUN);
    assign bus.halted    = (state_q == HALT);
    assign bus.redirect  = redirect_q;
    assign bus.misalign  = misalign_q;
    assign bus.fetch_cnt = cnt_q;
endmodule
